// File: rtl/push_sequencer.sv
// Sequencer for one push pass of the dual-pusher datapath. It reads particle pairs,
// issues them to the pusher pair, and writes the pushed pairs back in place.
module push_sequencer #(
    parameter int PART_ADDRWIDTH = 16,
    parameter int MEM_LATENCY    = 2,
    parameter int MAX_INFLIGHT   = 64,
    parameter int PARTICLE_WIDTH = 64
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [PART_ADDRWIDTH:0]             num_particles,
    input  logic                                phi_ready,
    output logic                                busy,
    output logic                                done,
    output logic                                mem_ren,
    output logic [PART_ADDRWIDTH-1:0]           mem_raddr,
    input  logic [1:0][PARTICLE_WIDTH-1:0]      mem_rdata,
    output logic                                push_valid,
    output logic                                push_noop,
    output logic                                push_tlast,
    output logic [1:0][PARTICLE_WIDTH-1:0]      push_particle,
    input  logic                                push_valid_out,
    input  logic [1:0][PARTICLE_WIDTH-1:0]      push_particle_out,
    input  logic                                push_tlast_out,
    output logic                                mem_wen,
    output logic [PART_ADDRWIDTH-1:0]           mem_waddr,
    output logic [1:0][PARTICLE_WIDTH-1:0]      mem_wdata,
    output logic [1:0]                          mem_wmask
);

    localparam int CW  = PART_ADDRWIDTH + 1;
    localparam int IFW = $clog2(MAX_INFLIGHT) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                           state_r;
    state_t                           state_nxt_s;
    logic [CW-1:0]                    npairs_r;
    logic                             odd_r;
    logic [CW-1:0]                    rd_cnt_r;
    logic [CW-1:0]                    wr_cnt_r;
    logic [CW-1:0]                    last_idx_s;
    logic [IFW-1:0]                   inflight_r;
    logic [MEM_LATENCY-1:0]           dly_valid_r;
    logic [MEM_LATENCY-1:0]           dly_tlast_r;
    logic [MEM_LATENCY-1:0]           dly_noop_r;
    logic                             ren_s;
    logic                             ret_s;
    logic                             wr_s;
    logic                             accept_s;
    logic                             last_rd_s;
    logic                             last_wr_s;
    logic                             wlast_r;
    logic                             mem_wen_r;
    logic [PART_ADDRWIDTH-1:0]        mem_waddr_r;
    logic [1:0][PARTICLE_WIDTH-1:0]   mem_wdata_r;
    logic [1:0]                       mem_wmask_r;

    assign last_idx_s = npairs_r - CW'(1);

    // Issue/return qualifiers and next-state logic.
    always_comb begin
        accept_s    = (state_r == S_IDLE) && start;
        ren_s       = (state_r == S_ISSUE) && phi_ready && (inflight_r < IFW'(MAX_INFLIGHT));
        ret_s       = push_valid_out && (inflight_r != {IFW{1'b0}});
        wr_s        = push_valid_out && ((state_r == S_ISSUE) || (state_r == S_DRAIN));
        last_rd_s   = (rd_cnt_r == last_idx_s);
        last_wr_s   = (wr_cnt_r == last_idx_s);
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    if (num_particles == {CW{1'b0}}) begin
                        state_nxt_s = S_DONE;
                    end else begin
                        state_nxt_s = S_ISSUE;
                    end
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (ren_s && last_rd_s) begin
                    state_nxt_s = S_DRAIN;
                end else begin
                    state_nxt_s = S_ISSUE;
                end
            end
            S_DRAIN: begin
                // The pass ends once the write of the final pair has been presented.
                if (mem_wen_r && wlast_r) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_DRAIN;
                end
            end
            S_DONE:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State register, pass parameters and read counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r  <= S_IDLE;
            npairs_r <= {CW{1'b0}};
            odd_r    <= 1'b0;
            rd_cnt_r <= {CW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                npairs_r <= (num_particles >> 1) + CW'(num_particles[0]);
                odd_r    <= num_particles[0];
                rd_cnt_r <= {CW{1'b0}};
            end else if (ren_s) begin
                rd_cnt_r <= rd_cnt_r + CW'(1);
            end
        end
    end

    // In-flight credit counter; stale returns with no credit outstanding are ignored.
    always_ff @(posedge clk) begin
        if (!rst) begin
            inflight_r <= {IFW{1'b0}};
        end else begin
            case ({ren_s, ret_s})
                2'b10:   inflight_r <= inflight_r + IFW'(1);
                2'b01:   inflight_r <= inflight_r - IFW'(1);
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    // Read-latency delay line carrying valid, tlast and noop alongside the memory read.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dly_valid_r <= {MEM_LATENCY{1'b0}};
            dly_tlast_r <= {MEM_LATENCY{1'b0}};
            dly_noop_r  <= {MEM_LATENCY{1'b0}};
        end else begin
            dly_valid_r[0] <= ren_s;
            dly_tlast_r[0] <= ren_s && last_rd_s;
            dly_noop_r[0]  <= ren_s && last_rd_s && odd_r;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                dly_valid_r[i] <= dly_valid_r[i-1];
                dly_tlast_r[i] <= dly_tlast_r[i-1];
                dly_noop_r[i]  <= dly_noop_r[i-1];
            end
        end
    end

    // Registered write-back of returned pairs; returns outside a pass are dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_wen_r   <= 1'b0;
            mem_waddr_r <= {PART_ADDRWIDTH{1'b0}};
            mem_wdata_r <= '0;
            mem_wmask_r <= 2'b00;
            wlast_r     <= 1'b0;
            wr_cnt_r    <= {CW{1'b0}};
        end else begin
            if (accept_s) begin
                wr_cnt_r <= {CW{1'b0}};
            end
            if (wr_s) begin
                mem_wen_r   <= 1'b1;
                mem_waddr_r <= wr_cnt_r[PART_ADDRWIDTH-1:0];
                mem_wdata_r <= push_particle_out;
                mem_wmask_r <= (last_wr_s && odd_r) ? 2'b01 : 2'b11;
                wlast_r     <= last_wr_s;
                wr_cnt_r    <= wr_cnt_r + CW'(1);
            end else begin
                mem_wen_r <= 1'b0;
                wlast_r   <= 1'b0;
            end
        end
    end

    // The tlast returned by the pusher is informational: the write counter decides the end.
    logic unused_tlast_s;
    assign unused_tlast_s = push_tlast_out;

    assign busy          = (state_r == S_ISSUE) || (state_r == S_DRAIN);
    assign done          = (state_r == S_DONE);
    assign mem_ren       = ren_s;
    assign mem_raddr     = rd_cnt_r[PART_ADDRWIDTH-1:0];
    assign push_valid    = dly_valid_r[MEM_LATENCY-1];
    assign push_tlast    = dly_valid_r[MEM_LATENCY-1] && dly_tlast_r[MEM_LATENCY-1];
    assign push_noop     = dly_valid_r[MEM_LATENCY-1] && dly_noop_r[MEM_LATENCY-1];
    assign push_particle = mem_rdata;
    assign mem_wen       = mem_wen_r;
    assign mem_waddr     = mem_waddr_r;
    assign mem_wdata     = mem_wdata_r;
    assign mem_wmask     = mem_wmask_r;

endmodule

// File: tb/tb_push_sequencer.sv
// Directed bench for push_sequencer with a latency-2 memory model and an in-order
// identity pusher model that can be held off.
module tb_push_sequencer;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [8:0]       num_particles;
    logic             phi_ready;
    logic             busy;
    logic             done;
    logic             mem_ren;
    logic [7:0]       mem_raddr;
    logic [1:0][15:0] mem_rdata;
    logic             push_valid;
    logic             push_noop;
    logic             push_tlast;
    logic [1:0][15:0] push_particle;
    logic             push_valid_out = 1'b0;
    logic [1:0][15:0] push_particle_out = '0;
    logic             push_tlast_out = 1'b0;
    logic             mem_wen;
    logic [7:0]       mem_waddr;
    logic [1:0][15:0] mem_wdata;
    logic [1:0]       mem_wmask;
    logic             hold;

    int total = 0;
    int bad   = 0;

    push_sequencer #(
        .PART_ADDRWIDTH(8), .MEM_LATENCY(2), .MAX_INFLIGHT(4), .PARTICLE_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_particles(num_particles),
        .phi_ready(phi_ready), .busy(busy), .done(done),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .push_valid(push_valid), .push_noop(push_noop), .push_tlast(push_tlast),
        .push_particle(push_particle), .push_valid_out(push_valid_out),
        .push_particle_out(push_particle_out), .push_tlast_out(push_tlast_out),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int i);
        logic [15:0] hi;
        logic [15:0] lo;
        hi = 16'(i * 3 + 256);
        lo = 16'(i ^ 32'h0000A5A5);
        return {hi, lo};
    endfunction

    // Memory model and event logs
    int               cyc = 0;
    logic [31:0]      d1 = '0;
    logic [31:0]      d2 = '0;
    int               n_ren = 0, n_pv = 0, n_wr = 0, n_done = 0;
    logic [7:0]       ren_addr [0:255];
    int               ren_cyc  [0:255];
    logic             ren_phi  [0:255];
    int               pv_cyc   [0:255];
    logic             pv_noop  [0:255];
    logic             pv_tlast [0:255];
    logic [31:0]      pv_data  [0:255];
    logic [7:0]       wr_addr  [0:255];
    logic [31:0]      wr_data  [0:255];
    logic [1:0]       wr_mask  [0:255];

    assign mem_rdata = d2;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        d1  <= pat(int'(mem_raddr));
        d2  <= d1;
        if (mem_ren) begin
            ren_addr[n_ren] <= mem_raddr;
            ren_cyc[n_ren]  <= cyc;
            ren_phi[n_ren]  <= phi_ready;
            n_ren <= n_ren + 1;
        end
        if (push_valid) begin
            pv_cyc[n_pv]   <= cyc;
            pv_noop[n_pv]  <= push_noop;
            pv_tlast[n_pv] <= push_tlast;
            pv_data[n_pv]  <= push_particle;
            n_pv <= n_pv + 1;
        end
        if (mem_wen) begin
            wr_addr[n_wr] <= mem_waddr;
            wr_data[n_wr] <= mem_wdata;
            wr_mask[n_wr] <= mem_wmask;
            n_wr <= n_wr + 1;
        end
        if (done) n_done <= n_done + 1;
    end

    // In-order identity pusher, one cycle deep, stallable by hold
    logic [31:0] pq_data [$];
    logic        pq_last [$];

    always @(posedge clk) begin
        if (push_valid) begin
            pq_data.push_back(push_particle);
            pq_last.push_back(push_tlast);
        end
        if (!hold && pq_data.size() > 0) begin
            push_valid_out    <= 1'b1;
            push_particle_out <= pq_data.pop_front();
            push_tlast_out    <= pq_last.pop_front();
        end else begin
            push_valid_out <= 1'b0;
            push_tlast_out <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input int n);
        start = 1'b1;
        num_particles = 9'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input int base);
        int k = 0;
        while (n_done == base && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", 32'(n_done - base), 32'd1);
    endtask

    int b_r, b_p, b_w, b_d, k;

    initial begin
        rst = 1'b0; start = 1'b0; num_particles = 9'd0; phi_ready = 1'b1; hold = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ren", 32'(mem_ren), 32'd0);
        chk("rst_raddr", 32'(mem_raddr), 32'd0);
        chk("rst_wen", 32'(mem_wen), 32'd0);
        chk("rst_pvalid", 32'(push_valid), 32'd0);
        chk("rst_wmask", 32'(mem_wmask), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 8 particles, unthrottled, plus an ignored start mid-pass
        b_r = n_ren; b_p = n_pv; b_w = n_wr; b_d = n_done;
        pulse_start(8);
        chk("t1_busy", 32'(busy), 32'd1);
        pulse_start(2);
        wait_done(100, b_d);
        repeat (3) @(negedge clk);
        chk("t1_nren", 32'(n_ren - b_r), 32'd4);
        chk("t1_npv", 32'(n_pv - b_p), 32'd4);
        chk("t1_nwr", 32'(n_wr - b_w), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_raddr", 32'(ren_addr[b_r+i]), 32'(i));
            chk("t1_rcyc", 32'(ren_cyc[b_r+i] - ren_cyc[b_r]), 32'(i));
            chk("t1_pvlat", 32'(pv_cyc[b_p+i] - ren_cyc[b_r+i]), 32'd2);
            chk("t1_tlast", 32'(pv_tlast[b_p+i]), (i == 3) ? 32'd1 : 32'd0);
            chk("t1_noop", 32'(pv_noop[b_p+i]), 32'd0);
            chk("t1_pdata", pv_data[b_p+i], pat(i));
            chk("t1_waddr", 32'(wr_addr[b_w+i]), 32'(i));
            chk("t1_wdata", wr_data[b_w+i], pat(i));
            chk("t1_wmask", 32'(wr_mask[b_w+i]), 32'd3);
        end
        chk("t1_done_once", 32'(n_done - b_d), 32'd1);
        chk("t1_busy_after", 32'(busy), 32'd0);

        // 5 particles: odd tail pair
        b_r = n_ren; b_p = n_pv; b_w = n_wr; b_d = n_done;
        pulse_start(5);
        wait_done(100, b_d);
        repeat (3) @(negedge clk);
        chk("t2_nren", 32'(n_ren - b_r), 32'd3);
        chk("t2_nwr", 32'(n_wr - b_w), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("t2_noop", 32'(pv_noop[b_p+i]), (i == 2) ? 32'd1 : 32'd0);
            chk("t2_tlast", 32'(pv_tlast[b_p+i]), (i == 2) ? 32'd1 : 32'd0);
            chk("t2_waddr", 32'(wr_addr[b_w+i]), 32'(i));
            chk("t2_wmask", 32'(wr_mask[b_w+i]), (i == 2) ? 32'd1 : 32'd3);
        end

        // Zero particles: done the cycle after start, no traffic
        b_r = n_ren; b_w = n_wr; b_d = n_done;
        start = 1'b1; num_particles = 9'd0;
        @(negedge clk);
        start = 1'b0;
        chk("t3_done_hi", 32'(done), 32'd1);
        chk("t3_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("t3_done_lo", 32'(done), 32'd0);
        chk("t3_busy2", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("t3_nren", 32'(n_ren - b_r), 32'd0);
        chk("t3_nwr", 32'(n_wr - b_w), 32'd0);
        chk("t3_ndone", 32'(n_done - b_d), 32'd1);

        // 20 particles with pusher held off: credit limit of 4
        b_r = n_ren; b_w = n_wr; b_d = n_done;
        hold = 1'b1;
        pulse_start(20);
        repeat (20) @(negedge clk);
        chk("t4_nren_held", 32'(n_ren - b_r), 32'd4);
        chk("t4_nwr_held", 32'(n_wr - b_w), 32'd0);
        chk("t4_busy_held", 32'(busy), 32'd1);
        hold = 1'b0;
        wait_done(200, b_d);
        repeat (3) @(negedge clk);
        chk("t4_nren", 32'(n_ren - b_r), 32'd10);
        chk("t4_nwr", 32'(n_wr - b_w), 32'd10);
        for (int i = 0; i < 10; i++) begin
            chk("t4_waddr", 32'(wr_addr[b_w+i]), 32'(i));
        end
        chk("t4_last_waddr", 32'(wr_addr[n_wr-1]), 32'd9);
        chk("t4_last_wmask", 32'(wr_mask[n_wr-1]), 32'd3);

        // 6 pairs with phi_ready toggling
        b_r = n_ren; b_w = n_wr; b_d = n_done;
        pulse_start(12);
        k = 0;
        while (n_done == b_d && k < 200) begin
            phi_ready = ~phi_ready;
            @(negedge clk);
            k++;
        end
        phi_ready = 1'b1;
        chk("t5_done_seen", 32'(n_done - b_d), 32'd1);
        repeat (3) @(negedge clk);
        chk("t5_nren", 32'(n_ren - b_r), 32'd6);
        chk("t5_nwr", 32'(n_wr - b_w), 32'd6);
        for (int i = 0; i < 6; i++) begin
            chk("t5_rphi", 32'(ren_phi[b_r+i]), 32'd1);
            chk("t5_raddr", 32'(ren_addr[b_r+i]), 32'(i));
            chk("t5_waddr", 32'(wr_addr[b_w+i]), 32'(i));
            chk("t5_wdata", wr_data[b_w+i], pat(i));
        end

        // Reset mid-pass, stale returns dropped, then a fresh 2-particle pass
        b_r = n_ren; b_w = n_wr; b_d = n_done;
        hold = 1'b1;
        pulse_start(12);
        k = 0;
        while ((n_ren - b_r) < 3 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("t6_inflight3", 32'((n_ren - b_r) >= 3), 32'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        hold = 1'b0;
        repeat (12) @(negedge clk);
        chk("t6_stale_nwr", 32'(n_wr - b_w), 32'd0);
        chk("t6_no_done", 32'(n_done - b_d), 32'd0);
        chk("t6_busy_idle", 32'(busy), 32'd0);
        pulse_start(2);
        wait_done(100, b_d);
        repeat (3) @(negedge clk);
        chk("t6_nwr", 32'(n_wr - b_w), 32'd1);
        chk("t6_waddr", 32'(wr_addr[b_w]), 32'd0);
        chk("t6_wdata", wr_data[b_w], pat(0));
        chk("t6_wmask", 32'(wr_mask[b_w]), 32'd3);
        chk("t6_done_once", 32'(n_done - b_d), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
